// File: rtl/calc_pkg.sv
// Shared state encoding, key codes and display constants for the calc_seq
// keypad calculator.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_A  = 3'd1,
        ST_GOT_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        KEY_OPERAND = 2'b00,
        KEY_ADD     = 2'b01,
        KEY_SUB     = 2'b10,
        KEY_CLEAR   = 2'b11
    } key_e;

    localparam logic [2:0] ERR_DISP_MAG  = 3'b111;
    localparam logic       ERR_DISP_SIGN = 1'b1;

    function automatic logic is_op_key(input key_e k);
        return (k == KEY_ADD) || (k == KEY_SUB);
    endfunction

endpackage

// File: rtl/add_sub.sv
// Sign-magnitude add/subtract of two 3-bit operands ([2] sign, [1:0] magnitude).
// Magnitude result spans 0..6; sign is not normalised when sf is zero.
module add_sub (
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    input  logic       Add_Sub,
    output logic [2:0] sf,
    output logic       sign
);

    logic       w_b_sign;
    logic [2:0] w_a_mag;
    logic [2:0] w_b_mag;

    // Subtraction is addition of B with its sign flipped.
    assign w_b_sign = b1[2] ^ Add_Sub;
    assign w_a_mag  = {1'b0, a1[1:0]};
    assign w_b_mag  = {1'b0, b1[1:0]};

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sf   = '0;
        sign = 1'b0;
        if (a1[2] == w_b_sign) begin
            sf   = w_a_mag + w_b_mag;
            sign = a1[2];
        end else if (w_a_mag >= w_b_mag) begin
            sf   = w_a_mag - w_b_mag;
            sign = a1[2];
        end else begin
            sf   = w_b_mag - w_a_mag;
            sign = w_b_sign;
        end
    end

endmodule

// File: rtl/calc_seq.sv
// Keypad calculator sequencer: collects A, operator, B, runs the add_sub
// datapath for EXEC_CYCLES cycles, then shows or chains the result.
module calc_seq
    import calc_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [1:0] key_type,
    input  logic [2:0] key_data,
    output logic       key_ready,
    output logic [2:0] disp_mag,
    output logic       disp_sign,
    output logic       result_valid,
    output logic       ovf,
    output logic       err
);

    localparam logic [2:0] CNT_INIT = 3'(EXEC_CYCLES - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [2:0] r_a;
    logic [2:0] w_a_nxt;
    logic [2:0] r_b;
    logic [2:0] w_b_nxt;
    logic       r_op;
    logic       w_op_nxt;
    logic [2:0] r_res_mag;
    logic [2:0] w_res_mag_nxt;
    logic       r_res_sign;
    logic       w_res_sign_nxt;
    logic       r_ovf;
    logic       w_ovf_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    logic       w_xfer;
    key_e       w_key;
    logic [2:0] w_sf;
    logic       w_sign;

    add_sub u_add_sub (
        .a1      (r_a),
        .b1      (r_b),
        .Add_Sub (r_op),
        .sf      (w_sf),
        .sign    (w_sign)
    );

    assign key_ready    = (r_state != ST_EXEC);
    assign w_xfer       = key_valid & key_ready;
    assign w_key        = key_e'(key_type);
    assign result_valid = (r_state == ST_EXEC) && (r_cnt == '0);
    assign err          = (r_state == ST_ERR);
    assign ovf          = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments so all registers update together on the edge.
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 1'b0;
            r_res_mag  <= '0;
            r_res_sign <= 1'b0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_op       <= w_op_nxt;
            r_res_mag  <= w_res_mag_nxt;
            r_res_sign <= w_res_sign_nxt;
            r_ovf      <= w_ovf_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_op_nxt       = r_op;
        w_res_mag_nxt  = r_res_mag;
        w_res_sign_nxt = r_res_sign;
        w_ovf_nxt      = r_ovf;
        w_cnt_nxt      = r_cnt;

        if (w_xfer && (w_key == KEY_CLEAR)) begin
            w_state_nxt    = ST_IDLE;
            w_a_nxt        = '0;
            w_b_nxt        = '0;
            w_op_nxt       = 1'b0;
            w_res_mag_nxt  = '0;
            w_res_sign_nxt = 1'b0;
            w_ovf_nxt      = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && (w_key == KEY_OPERAND)) begin
                        w_a_nxt     = key_data;
                        w_state_nxt = ST_GOT_A;
                    end
                end
                ST_GOT_A: begin
                    if (w_xfer && (w_key == KEY_OPERAND)) begin
                        w_a_nxt = key_data;
                    end else if (w_xfer && is_op_key(w_key)) begin
                        w_op_nxt    = (w_key == KEY_SUB);
                        w_state_nxt = ST_GOT_OP;
                    end
                end
                ST_GOT_OP: begin
                    if (w_xfer && (w_key == KEY_OPERAND)) begin
                        w_b_nxt     = key_data;
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = ST_EXEC;
                    end else if (w_xfer && is_op_key(w_key)) begin
                        w_op_nxt = (w_key == KEY_SUB);
                    end
                end
                ST_EXEC: begin
                    // A, B and op are frozen here, so the datapath output is stable.
                    if (r_cnt == '0) begin
                        w_res_mag_nxt  = w_sf;
                        w_res_sign_nxt = w_sign & (w_sf != '0);
                        w_ovf_nxt      = (w_sf > 3'd3);
                        w_state_nxt    = ST_SHOW;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                ST_SHOW: begin
                    if (w_xfer && (w_key == KEY_OPERAND)) begin
                        w_a_nxt     = key_data;
                        w_state_nxt = ST_GOT_A;
                    end else if (w_xfer && is_op_key(w_key)) begin
                        if (r_ovf) begin
                            w_state_nxt = ST_ERR;
                        end else begin
                            w_a_nxt     = {r_res_sign, r_res_mag[1:0]};
                            w_op_nxt    = (w_key == KEY_SUB);
                            w_state_nxt = ST_GOT_OP;
                        end
                    end
                end
                ST_ERR: begin
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        disp_mag  = '0;
        disp_sign = 1'b0;
        case (r_state)
            ST_GOT_A, ST_GOT_OP: begin
                disp_mag  = {1'b0, r_a[1:0]};
                disp_sign = r_a[2];
            end
            ST_EXEC: begin
                disp_mag  = {1'b0, r_b[1:0]};
                disp_sign = r_b[2];
            end
            ST_SHOW: begin
                disp_mag  = r_res_mag;
                disp_sign = r_res_sign;
            end
            ST_ERR: begin
                disp_mag  = ERR_DISP_MAG;
                disp_sign = ERR_DISP_SIGN;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: integer-arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_calc_seq;

    localparam int EXEC_CYCLES = 2;
    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_ADD  = 2'b01;
    localparam logic [1:0] K_SUB  = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [1:0] key_type;
    logic [2:0] key_data;
    logic       key_ready;
    logic [2:0] disp_mag;
    logic       disp_sign;
    logic       result_valid;
    logic       ovf;
    logic       err;

    int n_total = 0;
    int n_bad   = 0;

    calc_seq #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_type     (key_type),
        .key_data     (key_data),
        .key_ready    (key_ready),
        .disp_mag     (disp_mag),
        .disp_sign    (disp_sign),
        .result_valid (result_valid),
        .ovf          (ovf),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the calculator is doing, in plain integers.
    typedef enum int {M_IDLE, M_HAVE_A, M_HAVE_OP, M_BUSY, M_RESULT, M_LOCKED} mode_e;

    mode_e      m_mode   = M_IDLE;
    logic [2:0] m_a      = '0;
    logic [2:0] m_b      = '0;
    logic       m_sub    = 1'b0;
    logic [2:0] m_r_mag  = '0;
    logic       m_r_sign = 1'b0;
    logic       m_ovf    = 1'b0;
    int         m_left   = 0;

    function automatic int sval(input logic [2:0] x);
        return x[2] ? -int'(x[1:0]) : int'(x[1:0]);
    endfunction

    task automatic model_clear();
        m_mode   = M_IDLE;
        m_a      = '0;
        m_b      = '0;
        m_sub    = 1'b0;
        m_r_mag  = '0;
        m_r_sign = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step();
        bit xfer;
        int res;
        int mag;
        xfer = key_valid && (m_mode != M_BUSY);
        if (xfer && key_type == K_CLR) begin
            model_clear();
        end else begin
            case (m_mode)
                M_IDLE: if (xfer && key_type == K_OPND) begin
                    m_a = key_data; m_mode = M_HAVE_A;
                end
                M_HAVE_A: if (xfer) begin
                    if (key_type == K_OPND) m_a = key_data;
                    else begin m_sub = (key_type == K_SUB); m_mode = M_HAVE_OP; end
                end
                M_HAVE_OP: if (xfer) begin
                    if (key_type == K_OPND) begin
                        m_b = key_data; m_left = EXEC_CYCLES; m_mode = M_BUSY;
                    end else m_sub = (key_type == K_SUB);
                end
                M_BUSY: begin
                    m_left--;
                    if (m_left == 0) begin
                        res      = sval(m_a) + (m_sub ? -sval(m_b) : sval(m_b));
                        mag      = (res < 0) ? -res : res;
                        m_r_mag  = 3'(mag);
                        m_r_sign = (res < 0);
                        m_ovf    = (mag > 3);
                        m_mode   = M_RESULT;
                    end
                end
                M_RESULT: if (xfer) begin
                    if (key_type == K_OPND) begin
                        m_a = key_data; m_mode = M_HAVE_A;
                    end else if (!m_ovf) begin
                        m_a = {m_r_sign, m_r_mag[1:0]}; m_sub = (key_type == K_SUB); m_mode = M_HAVE_OP;
                    end else m_mode = M_LOCKED;
                end
                default: begin
                end
            endcase
        end
    endtask

    // Compare process: outputs checked mid-cycle, then the model takes this cycle's key.
    always @(negedge clk) begin
        int e_mag;
        int e_sign;
        if (!rst_n) begin
            model_clear();
            m_left = 0;
        end
        e_mag  = 0;
        e_sign = 0;
        case (m_mode)
            M_HAVE_A, M_HAVE_OP: begin e_mag = int'(m_a[1:0]); e_sign = int'(m_a[2]); end
            M_BUSY:              begin e_mag = int'(m_b[1:0]); e_sign = int'(m_b[2]); end
            M_RESULT:            begin e_mag = int'(m_r_mag);  e_sign = int'(m_r_sign); end
            M_LOCKED:            begin e_mag = 7;              e_sign = 1; end
            default:             begin end
        endcase
        check("mdl_key_ready", int'(key_ready), int'(m_mode != M_BUSY));
        check("mdl_disp_mag", int'(disp_mag), e_mag);
        check("mdl_disp_sign", int'(disp_sign), e_sign);
        check("mdl_result_valid", int'(result_valid), int'(m_mode == M_BUSY && m_left == 1));
        check("mdl_ovf", int'(ovf), int'(m_ovf));
        check("mdl_err", int'(err), int'(m_mode == M_LOCKED));
        if (rst_n) model_step();
    end

    task automatic send_w(input logic [1:0] kt, input logic [2:0] kd, output int waits);
        bit acc;
        acc       = 1'b0;
        waits     = 0;
        key_valid = 1'b1;
        key_type  = kt;
        key_data  = kd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = key_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
        end
        key_valid = 1'b0;
        if (!acc) check("send_accept", int'(acc), 1);
    endtask

    task automatic send(input logic [1:0] kt, input logic [2:0] kd);
        int w;
        send_w(kt, kd, w);
    endtask

    // Cycles from the B transfer edge to the result_valid cycle; returns just after capture.
    task automatic wait_result(input string name);
        int lat;
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = k;
                break;
            end
        end
        check(name, lat, EXEC_CYCLES);
        @(posedge clk);
        #1;
    endtask

    task automatic check_disp(input string name, input int mag, input int sgn);
        check({name, "_mag"}, int'(disp_mag), mag);
        check({name, "_sign"}, int'(disp_sign), sgn);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_key_ready"}, int'(key_ready), 1);
        check_disp(name, 0, 0);
        check({name, "_result_valid"}, int'(result_valid), 0);
        check({name, "_ovf"}, int'(ovf), 0);
        check({name, "_err"}, int'(err), 0);
    endtask

    initial begin
        int w;
        int rv_seen;
        int r;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_type  = K_OPND;
        key_data  = 3'b000;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // +2 + +1 = +3
        send(K_OPND, 3'b010);
        check_disp("a_plus2", 2, 0);
        send(K_ADD, 3'b000);
        send(K_OPND, 3'b001);
        check_disp("exec_shows_b", 1, 0);
        wait_result("lat_add");
        check_disp("res_plus3", 3, 0);
        check("res_plus3_ovf", int'(ovf), 0);

        // +1 - +3 = -2, then chained -2 + +3 = +1
        send(K_OPND, 3'b001);
        send(K_SUB, 3'b000);
        send(K_OPND, 3'b011);
        wait_result("lat_sub");
        check_disp("res_minus2", 2, 1);
        send(K_ADD, 3'b000);
        check_disp("chain_a", 2, 1);
        send(K_OPND, 3'b011);
        wait_result("lat_chain");
        check_disp("res_chain_plus1", 1, 0);

        // -2 + -3 = -5 overflows; chaining is refused
        send(K_OPND, 3'b110);
        send(K_ADD, 3'b000);
        send(K_OPND, 3'b111);
        wait_result("lat_ovf");
        check_disp("res_minus5", 5, 1);
        check("res_minus5_ovf", int'(ovf), 1);
        send(K_SUB, 3'b000);
        check("err_entered", int'(err), 1);
        check_disp("err_disp", 7, 1);
        send(K_OPND, 3'b001);
        check("err_holds", int'(err), 1);
        check_disp("err_holds", 7, 1);
        send(K_CLR, 3'b000);
        check("clear_err", int'(err), 0);
        check("clear_ovf", int'(ovf), 0);
        check_disp("clear_disp", 0, 0);

        // -1 + +1 = 0 shown as positive zero
        send(K_OPND, 3'b101);
        send(K_ADD, 3'b000);
        send(K_OPND, 3'b001);
        wait_result("lat_zero");
        check_disp("res_zero", 0, 0);

        // negative-zero operand kept as entered
        send(K_OPND, 3'b100);
        check_disp("neg_zero_a", 0, 1);
        send(K_ADD, 3'b000);
        send(K_OPND, 3'b011);
        wait_result("lat_negzero");
        check_disp("res_negzero_plus3", 3, 0);

        // key held through EXEC waits and lands in SHOW
        send(K_OPND, 3'b001);
        send(K_ADD, 3'b000);
        send(K_OPND, 3'b010);
        send_w(K_OPND, 3'b011, w);
        check("exec_stall_cycles", w, EXEC_CYCLES);
        check_disp("after_stall_a", 3, 0);

        // reset during EXEC aborts the operation
        send(K_CLR, 3'b000);
        send(K_OPND, 3'b001);
        send(K_ADD, 3'b000);
        send(K_OPND, 3'b010);
        check_disp("pre_reset_b", 2, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_exec_reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rv_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        check("no_rv_after_reset", rv_seen, 0);
        check_disp("idle_after_reset", 0, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            key_valid = ($urandom_range(0, 9) < 7);
            r         = int'($urandom_range(0, 15));
            key_type  = (r == 0) ? K_CLR : (r < 7) ? K_OPND : (r < 11) ? K_ADD : K_SUB;
            key_data  = 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
